// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

  localparam logic [31:0] SW_ADDR      = 32'hC000_0000;
  localparam logic [31:0] LED_ADDR     = 32'hC000_0004;
  localparam int unsigned MAX_LOCK_DEF = 8;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-master winner selection. Defining DMEM_ARB_RR_EN gives round-robin on IDLE ties;
// otherwise m0 has fixed priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  arb_state_t state,
  output logic       winner,
  output logic       valid
);

  logic tie_pick;

`ifdef DMEM_ARB_RR_EN
  assign tie_pick = ~last;
`else
  logic unused_last;
  assign unused_last = last;
  assign tie_pick    = 1'b0;
`endif

  always_comb begin
    winner = 1'b0;
    valid  = 1'b0;
    unique case (state)
      OWN0: begin
        winner = 1'b0;
        valid  = req[0];
      end
      OWN1: begin
        winner = 1'b1;
        valid  = req[1];
      end
      default: begin
        valid  = |req;
        winner = (&req) ? tie_pick : req[1];
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer granting the single-port data memory to one of two masters per cycle,
// with bounded locked bursts. Tie policy selected by DMEM_ARB_RR_EN (see dmem_arb_pick).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 32,
  parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int unsigned   CW        = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 1);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          last_q, last_d;
  logic          winner, pick_valid, gnt_any, gnt_lock;
  logic          rd0, rd1;
  logic          rvalid0_q, rvalid1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  dmem_arb_pick u_pick (
    .req    ({m1_req, m0_req}),
    .last   (last_q),
    .state  (state_q),
    .winner (winner),
    .valid  (pick_valid)
  );

  // Gated by reset so the memory bus goes quiet the instant reset asserts.
  assign gnt_any = pick_valid & reset_n;
  assign m0_gnt  = gnt_any & ~winner;
  assign m1_gnt  = gnt_any & winner;
  assign rd0     = m0_gnt & ~m0_we;
  assign rd1     = m1_gnt & ~m1_we;

  always_comb begin
    mem_we   = 1'b0;
    mem_a    = '0;
    mem_wd   = '0;
    gnt_lock = 1'b0;
    if (m0_gnt) begin
      mem_we   = m0_we;
      mem_a    = m0_addr;
      mem_wd   = m0_wdata;
      gnt_lock = m0_lock;
    end else if (m1_gnt) begin
      mem_we   = m1_we;
      mem_a    = m1_addr;
      mem_wd   = m1_wdata;
      gnt_lock = m1_lock;
    end
  end

  // Any cycle without a continuing lock (no grant, unlocked grant, or the MAX_LOCK-th
  // grant of a burst) falls back to IDLE with the counter cleared.
  always_comb begin
    state_d    = IDLE;
    lock_cnt_d = '0;
    last_d     = last_q;
    if (gnt_any) begin
      last_d = winner;
      if (gnt_lock && (lock_cnt_q != LOCK_LAST)) begin
        state_d    = winner ? OWN1 : OWN0;
        lock_cnt_d = lock_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      last_q     <= 1'b1;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      last_q     <= last_d;
      rvalid0_q  <= rd0;
      rvalid1_q  <= rd1;
      if (rd0) rdata0_q <= mem_rd;
      if (rd1) rdata1_q <= mem_rd;
    end
  end

  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter against a transaction-level reference model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned MAXL   = 8;
  localparam logic [31:0] SW_VAL = 32'h5A5A_0F0F;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_a, mem_wd, mem_rd;

  dmem_arbiter #(.DW(32), .AW(32), .MAX_LOCK(MAXL)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_lock   (m0_lock),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_lock   (m1_lock),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  always #5 clk = ~clk;

  // Environment: small RAM, switch and LED registers behind the memory port.
  logic [31:0] ram [64] = '{default: '0};
  logic [31:0] led = '0;
  assign mem_rd = (mem_a == SW_ADDR)  ? SW_VAL :
                  (mem_a == LED_ADDR) ? led    :
                  (mem_a < 32'h100)   ? ram[mem_a[7:2]] : 32'h0;
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_a == LED_ADDR) led <= mem_wd;
      else if (mem_a < 32'h100) ram[mem_a[7:2]] <= mem_wd;
    end
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: owner (-1 = none), grants in current burst, last granted, memory image.
  int          owner = -1, burst = 0, last = 1, gw = -1;
  int          g0 = 0, g1 = 0;
  logic [31:0] mdl [logic [31:0]];
  logic [31:0] exp0 [$], exp1 [$];
  logic [31:0] last0 = '0, last1 = '0;
  bit          pend [2] = '{0, 0};

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    if (a == SW_ADDR) return SW_VAL;
    if (mdl.exists(a)) return mdl[a];
    return 32'h0;
  endfunction

  // Called at a falling edge with inputs already driven; checks and advances one cycle.
  task automatic step();
    logic        we, lk;
    logic [31:0] a, d;
    #2;
    gw = -1;
    if (owner < 0) begin
      if (m0_req && m1_req) gw = RR ? 1 - last : 0;
      else if (m0_req)      gw = 0;
      else if (m1_req)      gw = 1;
    end else if ((owner == 0 && m0_req) || (owner == 1 && m1_req)) begin
      gw = owner;
    end
    g0 += int'(m0_gnt);
    g1 += int'(m1_gnt);
    chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, gw == 0});
    chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, gw == 1});
    if (gw >= 0) begin
      we = (gw == 0) ? m0_we    : m1_we;
      lk = (gw == 0) ? m0_lock  : m1_lock;
      a  = (gw == 0) ? m0_addr  : m1_addr;
      d  = (gw == 0) ? m0_wdata : m1_wdata;
      chk("mem_we", {31'd0, mem_we}, {31'd0, we});
      chk("mem_a", mem_a, a);
      chk("mem_wd", mem_wd, d);
      if (we) begin
        if (a != SW_ADDR) mdl[a] = d;
      end else if (gw == 0) exp0.push_back(mdl_rd(a));
      else exp1.push_back(mdl_rd(a));
      last = gw;
      burst++;
      if (lk && burst < int'(MAXL)) owner = gw;
      else begin owner = -1; burst = 0; end
    end else begin
      chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
      chk("idle_mem_a", mem_a, 32'd0);
      chk("idle_mem_wd", mem_wd, 32'd0);
      owner = -1;
      burst = 0;
    end
    @(negedge clk);
  endtask

  // Monitor: pops expected read data whenever a read response is presented.
  always @(posedge clk) begin
    #1;
    if (m0_rvalid) begin
      if (exp0.size() == 0) chk("m0_rvalid_spurious", 32'd1, 32'd0);
      else begin last0 = exp0.pop_front(); chk("m0_rdata", m0_rdata, last0); end
    end else chk("m0_rdata_hold", m0_rdata, last0);
    if (m1_rvalid) begin
      if (exp1.size() == 0) chk("m1_rvalid_spurious", 32'd1, 32'd0);
      else begin last1 = exp1.pop_front(); chk("m1_rdata", m1_rdata, last1); end
    end else chk("m1_rdata_hold", m1_rdata, last1);
  end

  task automatic drv(input int m, input logic r, input logic w, input logic l,
                     input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin m0_req = r; m0_we = w; m0_lock = l; m0_addr = a; m0_wdata = d; end
    else begin m1_req = r; m1_we = w; m1_lock = l; m1_addr = a; m1_wdata = d; end
  endtask

  task automatic new_txn(input int m);
    logic        r;
    logic [31:0] a;
    int          sel;
    r   = ($urandom_range(0, 3) != 0);
    sel = $urandom_range(0, 9);
    a   = (sel == 0) ? LED_ADDR : (sel == 1) ? SW_ADDR : 32'($urandom_range(0, 15)) << 2;
    drv(m, r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
    pend[m] = r;
  endtask

  initial begin
    drv(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drv(1, 1'b1, 1'b1, 1'b0, 32'h8, 32'hFFFF_FFFF);
    #1 reset_n = 1'b0;
    @(negedge clk);
    #2;
    chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    chk("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Tie in IDLE, both reading.
    drv(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drv(1, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    repeat (4) step();

    // Single master write then read.
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h1234_5678);
    step();
    drv(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    step();
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("single_rdata", m0_rdata, 32'h1234_5678);

    // Locked burst by m1 while m0 waits.
    g0 = 0; g1 = 0;
    drv(1, 1'b1, 1'b1, 1'b1, 32'h20, $urandom);
    step();
    for (int k = 1; k < 8; k++) begin
      drv(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
      drv(1, 1'b1, 1'b1, 1'b1, 32'h20 + 32'(4 * k), $urandom);
      step();
    end
    chk("burst_m1_gnts", 32'(g1), 32'd8);
    chk("burst_m0_held", 32'(g0), 32'd0);
    drv(1, 1'b1, 1'b1, 1'b0, 32'h40, 32'hCAFE_0040);
    step();
    chk("burst_m0_after", 32'(g0), 32'd1);
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("burst_m1_next", 32'(g1), 32'd9);

    // Peripheral pass-through.
    drv(1, 1'b1, 1'b1, 1'b0, LED_ADDR, 32'h3FF);
    step();
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("led_value", led, 32'h3FF);

    // Owner drops req while locked, m1 pending.
    g1 = 0;
    drv(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    drv(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    step();
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("drop_bubble", 32'(g1), 32'd0);
    step();
    chk("drop_m1_gnt", 32'(g1), 32'd1);

    // Reset during a granted read in OWN0.
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    step();
    drv(0, 1'b1, 1'b0, 1'b1, 32'h14, 32'h0);
    #2 reset_n = 1'b0;
    last0 = '0; last1 = '0;
    #1;
    chk("rstmid_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("rstmid_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    chk("rstmid_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rstmid_mem_a", mem_a, 32'd0);
    chk("rstmid_mem_wd", mem_wd, 32'd0);
    owner = -1; burst = 0; last = 1;
    exp0.delete(); exp1.delete();
    @(negedge clk);
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset_n = 1'b1;

    // Randomized traffic.
    gw = -1;
    for (int c = 0; c < 600; c++) begin
      for (int m = 0; m < 2; m++) if (!pend[m] || gw == m) new_txn(m);
      step();
    end
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) step();
    chk("drain_m0", 32'(exp0.size()), 32'd0);
    chk("drain_m1", 32'(exp1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter and sequencer for the single-port data memory and its memory-mapped peripherals (switches at 0xC000_0000, LEDs at 0xC000_0004). Port 0 is the processor's load/store path; port 1 is a secondary master, either a program/data loader or a debug port. Each cycle the block grants the memory to at most one master and supports short locked bursts. It returns registered read data with a valid strobe and drives the memory's `we`/`a`/`wd`, consuming its combinational `rd`.

## Interface
- `DW`, 32, data width of the memory and both masters
- `AW`, 32, byte-address width
- `MAX_LOCK`, 8, maximum consecutive cycles one master may hold a lock before forced release (≥2)
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `m0_req`, `m1_req`  in  1  access request, held until granted
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_lock`, `m1_lock`  in  1  keep ownership after this access
- `m0_addr`, `m1_addr`  in  AW  byte address, word-aligned
- `m0_wdata`, `m1_wdata`  in  DW  write data
- `m0_gnt`, `m1_gnt`  out  1  access accepted this cycle (combinational); processor uses `!m0_gnt & m0_req` as stall
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid, one cycle after a granted read
- `m0_rdata`, `m1_rdata`  out  DW  registered read data
- `mem_we`  out  1  memory write enable
- `mem_a`  out  AW  memory address
- `mem_wd`  out  DW  memory write data
- `mem_rd`  in  DW  memory read data (combinational from `mem_a`)

## Operation
- States: `IDLE` (no owner), `OWN0`, `OWN1`. In `IDLE` a requester is chosen per arbitration policy; in `OWNx` only master x can be granted, and the other's `req` waits.
- Grant in the cycle `req` is seen (if eligible): `mxx_gnt`=1, `mem_a`/`mem_we`/`mem_wd` are muxed from the granted master. Write commits at the next rising edge.
- Ungranted cycle: `mem_we`=0, `mem_a`=0, `mem_wd`=0.
- Granted with `lock`=1: next state `OWNx` and lock counter increments. Granted with `lock`=0, or owner's `req` drops: next state `IDLE`.
- Lock counter: cleared on entering `IDLE`. When it reaches `MAX_LOCK`, the access in that cycle completes and the state is forced to `IDLE`. Policy then treats the same master as most recent.
- Read: on a granted read, `mem_rd` is captured into `mxx_rdata` at the edge, and `mxx_rvalid` pulses high for one cycle. `rdata` holds until the next read of that master.
- Simultaneous requests in `IDLE` go to the arbitration policy (see Configuration).
- A request to an address outside RAM and peripherals is passed through unchanged. Decoding belongs to the memory.

## Timing
- Reset (async assert, sync deassert is external): state `IDLE`, lock counter 0, last-granted = 1, all `gnt`/`rvalid` = 0, `rdata` = 0, `mem_*` = 0.
- Reset mid-burst drops ownership immediately. An in-flight `rvalid` is cleared.
- Grant latency: 0 cycles when eligible. Read latency: 1 cycle (`rvalid` at edge+1). Write latency: 1 edge.
- Sustained throughput: 1 access/cycle. A master with `req` held is granted within `MAX_LOCK`+1 cycles.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin. On a tie in `IDLE`, grant the master not granted most recently (last-granted register, reset value 1, so m0 wins the first tie).
- Not defined: fixed priority. m0 always wins ties. `MAX_LOCK` still bounds m1 bursts, but m1 can starve while m0 requests continuously.

## Structure
- Package `dmem_arb_pkg`: `typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t`, peripheral address constants `SW_ADDR = 32'hC000_0000` and `LED_ADDR = 32'hC000_0004`, default `MAX_LOCK`.
- One sub-module, `dmem_arb_pick`: two-input pick logic taking `req`, last-granted and state, and returning the winner index. Round-robin vs fixed priority is selected by the macro inside it.

## Test plan
- Single master: m0 writes 0x1234_5678 to 0x10, then reads 0x10 → `m0_gnt` high in both cycles; `m0_rvalid` high one cycle later with `m0_rdata`=0x1234_5678.
- Tie in `IDLE`, both reading: with RR, grants alternate m0,m1,m0,m1 over 4 cycles; without RR, m0 is granted all 4 cycles and `m1_gnt` stays 0.
- Lock burst: m1 writes 0x20..0x3C with lock=1 and `MAX_LOCK`=8 while m0 requests → m1 gets 8 grants, state then returns to `IDLE`, and m0 is granted on cycle 9 (RR).
- Peripheral pass-through: m1 writes 0x3FF to 0xC000_0004 → `mem_a`=0xC000_0004 and `mem_we`=1 for one cycle; LEDs read 0x3FF.
- Reset mid-operation: assert `reset_n`=0 during a granted m0 read in `OWN0` → `m0_rvalid`=0, state `IDLE`, all `mem_*`=0 immediately, with no clock edge.
- Owner drops `req` while locked in `OWN0`, with m1 pending → next cycle is `IDLE` and m1 is granted.
